// File: rtl/lal_down_counter_cmp.sv
// Loadable down-counter with saturate/auto-reload modes and a run FSM, plus an
// independent registered unsigned magnitude comparator with a hold gate.
module lal_down_counter_cmp #(
    parameter int WIDTH          = 9,
    parameter int CMP_WIDTH      = 4,
    parameter int RELOAD_DEFAULT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 en,
    input  logic                 mode_wr,
    input  logic                 mode_in,
    input  logic                 hold,
    input  logic [CMP_WIDTH-1:0] cmp_a,
    input  logic [CMP_WIDTH-1:0] cmp_b,
    input  logic                 cmp_valid,
    output logic [WIDTH-1:0]     count,
    output logic                 zero,
    output logic                 tc_pulse,
    output logic                 busy,
    output logic                 cmp_eq,
    output logic                 cmp_gt,
    output logic                 cmp_lt,
    output logic                 cmp_out_valid
);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] reload_reg, reload_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;
    logic             mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Priority chain clr > load > hold > en; mode is the value registered before this edge.
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload_reg;
        tc_nxt     = 1'b0;
        if (clr) begin
            count_nxt = '0;
            state_nxt = IDLE;
        end else if (load) begin
            count_nxt  = load_val;
            reload_nxt = load_val;
            state_nxt  = (load_val != '0) ? RUN : IDLE;
        end else if (!hold && en && state == RUN) begin
            if (count > ONE) begin
                count_nxt = count - ONE;
            end else if (count == ONE) begin
                count_nxt = '0;
                tc_nxt    = 1'b1;
                if (!mode) begin
                    state_nxt = EXPIRED;
                end
            end else if (mode) begin
                // Sitting at zero after expiry: restart the period, unless that would loop on zero.
                count_nxt = reload_reg;
                if (reload_reg == '0) begin
                    state_nxt = IDLE;
                end
            end else begin
                state_nxt = EXPIRED;
            end
        end
    end

    always_comb begin
        busy = (state == RUN);
        zero = (count == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            reload_reg <= '0;
            tc_pulse   <= 1'b0;
            mode       <= 1'(RELOAD_DEFAULT);
        end else begin
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            tc_pulse   <= tc_nxt;
            if (mode_wr) begin
                mode <= mode_in;
            end
        end
    end

    // Result flags keep their last capture; only the valid tag drops when nothing is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_eq        <= 1'b0;
            cmp_gt        <= 1'b0;
            cmp_lt        <= 1'b0;
            cmp_out_valid <= 1'b0;
        end else begin
            cmp_out_valid <= cmp_valid & ~hold;
            if (cmp_valid && !hold) begin
                cmp_eq <= (cmp_a == cmp_b);
                cmp_gt <= (cmp_a > cmp_b);
                cmp_lt <= (cmp_a < cmp_b);
            end
        end
    end

endmodule

// File: tb/tb_lal_down_counter_cmp.sv
// Self-checking bench for lal_down_counter_cmp: directed scenarios plus a
// randomized run checked against a behavioural model of the counter and comparator.
`timescale 1ns/100ps
module tb_lal_down_counter_cmp;

    localparam int W  = 9;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0, load = 1'b0, en = 1'b0, mode_wr = 1'b0, mode_in = 1'b0, hold = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [CW-1:0] cmp_a = '0, cmp_b = '0;
    logic          cmp_valid = 1'b0;
    logic [W-1:0]  count;
    logic          zero, tc_pulse, busy, cmp_eq, cmp_gt, cmp_lt, cmp_out_valid;

    int checks = 0;
    int failures = 0;

    // Behavioural model: phase 0 = idle, 1 = counting, 2 = expired
    int m_count, m_reload, m_phase;
    bit m_mode, m_tc, m_eq, m_gt, m_lt, m_cv;

    lal_down_counter_cmp #(.WIDTH(W), .CMP_WIDTH(CW), .RELOAD_DEFAULT(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en),
        .mode_wr(mode_wr), .mode_in(mode_in), .hold(hold), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_valid(cmp_valid), .count(count), .zero(zero), .tc_pulse(tc_pulse), .busy(busy),
        .cmp_eq(cmp_eq), .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_out_valid(cmp_out_valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_count = 0; m_reload = 0; m_phase = 0; m_mode = 1'b0;
        m_tc = 1'b0; m_eq = 1'b0; m_gt = 1'b0; m_lt = 1'b0; m_cv = 1'b0;
    endtask

    task automatic model_step();
        bit tc;
        tc = 1'b0;
        if (clr) begin
            m_count = 0; m_phase = 0;
        end else if (load) begin
            m_count = int'(load_val); m_reload = int'(load_val);
            m_phase = (load_val != 0) ? 1 : 0;
        end else if (!hold && en && m_phase == 1) begin
            if (m_count >= 2) m_count = m_count - 1;
            else if (m_count == 1) begin
                m_count = 0; tc = 1'b1;
                if (!m_mode) m_phase = 2;
            end else if (m_mode) begin
                m_count = m_reload;
                if (m_reload == 0) m_phase = 0;
            end else m_phase = 2;
        end
        m_tc = tc;
        if (mode_wr) m_mode = mode_in;
        if (cmp_valid && !hold) begin
            m_eq = (cmp_a == cmp_b); m_gt = (cmp_a > cmp_b); m_lt = (cmp_a < cmp_b); m_cv = 1'b1;
        end else m_cv = 1'b0;
    endtask

    task automatic idle_inputs();
        clr = 0; load = 0; en = 0; mode_wr = 0; mode_in = 0; hold = 0; cmp_valid = 0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_mode(input bit m);
        idle_inputs(); mode_wr = 1; mode_in = m; cycle(); idle_inputs();
    endtask

    task automatic test_reset();
        rst_n = 0; idle_inputs(); model_reset();
        #12;
        checks++; if (count !== '0 || busy !== 1'b0 || tc_pulse !== 1'b0) begin failures++; $display("[TB] FAIL reset_init count=%0d busy=%0b tc=%0b expected 0/0/0", count, busy, tc_pulse); end
        @(negedge clk); rst_n = 1;
        cycle();
        load = 1; load_val = 9'd5; cmp_valid = 1; cmp_a = 4'd9; cmp_b = 4'd4; cycle(); idle_inputs();
        checks++; if (count !== 9'd5 || busy !== 1'b1 || cmp_gt !== 1'b1) begin failures++; $display("[TB] FAIL reset_preload count=%0d busy=%0b gt=%0b expected 5/1/1", count, busy, cmp_gt); end
        #2; rst_n = 0; #0.5;
        checks++; if (count !== '0 || busy !== 1'b0 || {cmp_eq, cmp_gt, cmp_lt, cmp_out_valid} !== 4'b0) begin failures++; $display("[TB] FAIL reset_async count=%0d busy=%0b cmp=%b expected 0/0/0000", count, busy, {cmp_eq, cmp_gt, cmp_lt, cmp_out_valid}); end
        #0.5; rst_n = 1; model_reset();
        checks++; if (count !== '0 || zero !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_release count=%0d zero=%0b busy=%0b expected 0/1/0", count, zero, busy); end
    endtask

    task automatic test_saturate();
        int exp_seq[4] = '{3, 2, 1, 0};
        set_mode(1'b0);
        load = 1; load_val = 9'd3; cycle(); load = 0; en = 1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (count !== 9'(exp_seq[i]) || tc_pulse !== (i == 3)) begin failures++; $display("[TB] FAIL sat_seq[%0d] count=%0d tc=%0b expected %0d/%0b", i, count, tc_pulse, exp_seq[i], i == 3); end
            if (i < 3) cycle();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL sat_expired busy=%0b expected 0", busy); end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (count !== '0 || tc_pulse !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL sat_stay[%0d] count=%0d tc=%0b busy=%0b expected 0/0/0", i, count, tc_pulse, busy); end
        end
        idle_inputs();
    endtask

    task automatic test_reload();
        int tcs = 0;
        set_mode(1'b1);
        load = 1; load_val = 9'd2; cycle(); load = 0; en = 1;
        checks++; if (count !== 9'd2) begin failures++; $display("[TB] FAIL reload_start count=%0d expected 2", count); end
        for (int i = 1; i <= 9; i++) begin
            cycle();
            if (tc_pulse) tcs++;
            checks++; if (count !== 9'(2 - (i % 3)) || tc_pulse !== (i % 3 == 2) || busy !== 1'b1) begin failures++; $display("[TB] FAIL reload_seq[%0d] count=%0d tc=%0b busy=%0b expected %0d/%0b/1", i, count, tc_pulse, busy, 2 - (i % 3), i % 3 == 2); end
        end
        checks++; if (tcs != 3) begin failures++; $display("[TB] FAIL reload_tc_count got=%0d expected 3", tcs); end
        idle_inputs();
    endtask

    task automatic test_priority();
        load = 1; load_val = 9'd4; cycle();
        clr = 1; load = 1; load_val = 9'd7; en = 1; cycle(); idle_inputs();
        checks++; if (count !== '0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL prio_clr count=%0d busy=%0b expected 0/0", count, busy); end
        load = 1; load_val = 9'd6; cycle(); load = 0;
        hold = 1; en = 1; cycle();
        checks++; if (count !== 9'd6 || busy !== 1'b1) begin failures++; $display("[TB] FAIL prio_hold count=%0d busy=%0b expected 6/1", count, busy); end
        hold = 0; cycle();
        checks++; if (count !== 9'd5) begin failures++; $display("[TB] FAIL prio_release count=%0d expected 5", count); end
        clr = 1; cycle(); idle_inputs();
    endtask

    task automatic test_comparator();
        cmp_valid = 1; cmp_a = 4'd9; cmp_b = 4'd4; cycle();
        checks++; if ({cmp_eq, cmp_gt, cmp_lt, cmp_out_valid} !== 4'b0101) begin failures++; $display("[TB] FAIL cmp_gt flags=%b expected 0101", {cmp_eq, cmp_gt, cmp_lt, cmp_out_valid}); end
        cmp_a = 4'd4; cmp_b = 4'd4; hold = 1; cycle();
        checks++; if ({cmp_eq, cmp_gt, cmp_lt, cmp_out_valid} !== 4'b0100) begin failures++; $display("[TB] FAIL cmp_hold flags=%b expected 0100", {cmp_eq, cmp_gt, cmp_lt, cmp_out_valid}); end
        hold = 0; cycle();
        checks++; if ({cmp_eq, cmp_gt, cmp_lt, cmp_out_valid} !== 4'b1001) begin failures++; $display("[TB] FAIL cmp_eq flags=%b expected 1001", {cmp_eq, cmp_gt, cmp_lt, cmp_out_valid}); end
        cmp_a = 4'd2; cmp_b = 4'd11; clr = 1; cycle();
        checks++; if ({cmp_eq, cmp_gt, cmp_lt, cmp_out_valid} !== 4'b0011) begin failures++; $display("[TB] FAIL cmp_lt flags=%b expected 0011", {cmp_eq, cmp_gt, cmp_lt, cmp_out_valid}); end
        idle_inputs(); cycle();
        checks++; if ({cmp_eq, cmp_gt, cmp_lt, cmp_out_valid} !== 4'b0010) begin failures++; $display("[TB] FAIL cmp_novalid flags=%b expected 0010", {cmp_eq, cmp_gt, cmp_lt, cmp_out_valid}); end
    endtask

    task automatic test_boundary();
        int tcs = 0;
        set_mode(1'b0);
        load = 1; load_val = 9'd1; cycle(); load = 0; en = 1; cycle();
        checks++; if (count !== '0 || tc_pulse !== 1'b1 || busy !== 1'b0) begin failures++; $display("[TB] FAIL bnd_load1 count=%0d tc=%0b busy=%0b expected 0/1/0", count, tc_pulse, busy); end
        en = 0; load = 1; load_val = 9'd0; cycle(); load = 0; en = 1; cycle();
        checks++; if (count !== '0 || tc_pulse !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL bnd_load0 count=%0d tc=%0b busy=%0b expected 0/0/0", count, tc_pulse, busy); end
        set_mode(1'b1);
        load = 1; load_val = 9'd511; cycle(); load = 0; en = 1;
        for (int i = 0; i < 512; i++) begin
            cycle();
            if (tc_pulse) tcs++;
        end
        checks++; if (count !== 9'd511 || busy !== 1'b1 || tcs != 1) begin failures++; $display("[TB] FAIL bnd_wrap511 count=%0d busy=%0b tcs=%0d expected 511/1/1", count, busy, tcs); end
        clr = 1; en = 0; cycle(); idle_inputs();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            clr       = ($urandom_range(0, 39) == 0);
            load      = ($urandom_range(0, 11) == 0);
            load_val  = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 5));
            hold      = ($urandom_range(0, 7) == 0);
            en        = ($urandom_range(0, 3) != 0);
            mode_wr   = ($urandom_range(0, 15) == 0);
            mode_in   = 1'($urandom);
            cmp_valid = 1'($urandom);
            cmp_a     = CW'($urandom);
            cmp_b     = ($urandom_range(0, 3) == 0) ? cmp_a : CW'($urandom);
            cycle();
            checks++; if (count !== W'(m_count)) begin failures++; $display("[TB] FAIL rnd_count[%0d] got=%0d expected %0d", i, count, m_count); end
            checks++; if (zero !== (m_count == 0)) begin failures++; $display("[TB] FAIL rnd_zero[%0d] got=%0b expected %0b", i, zero, m_count == 0); end
            checks++; if (tc_pulse !== m_tc) begin failures++; $display("[TB] FAIL rnd_tc[%0d] got=%0b expected %0b", i, tc_pulse, m_tc); end
            checks++; if (busy !== (m_phase == 1)) begin failures++; $display("[TB] FAIL rnd_busy[%0d] got=%0b expected %0b", i, busy, m_phase == 1); end
            checks++; if ({cmp_eq, cmp_gt, cmp_lt, cmp_out_valid} !== {m_eq, m_gt, m_lt, m_cv}) begin failures++; $display("[TB] FAIL rnd_cmp[%0d] got=%b expected %b", i, {cmp_eq, cmp_gt, cmp_lt, cmp_out_valid}, {m_eq, m_gt, m_lt, m_cv}); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_reload();
        test_priority();
        test_comparator();
        test_boundary();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
